// File: rtl/secuenciador_suma_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
package secuenciador_suma_pkg;

  // Default operand width in bytes (legal range 2..8).
  localparam int NBYTES_DEFAULT = 4;

  // Sequencer states; the unused code 2'd3 falls back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/secuenciador_suma_sumador.sv
// Sumador_3: 8-bit ripple-carry adder shared by the sequencer, one byte per clock.
module Sumador_3 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [8:0] c;

  // Ripple the carry through eight full-adder cells.
  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[8];
  end

endmodule

// File: rtl/secuenciador_suma.sv
// secuenciador_suma: wide add/subtract computed one byte per clock, LSB first,
// through a single shared 8-bit adder with the carry chained in a register.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid are decoded from the state register only,
// so neither has a combinational path from in_valid or out_ready. Once
// out_valid is high, result and flags stay stable until out_ready is seen.
module secuenciador_suma
  import secuenciador_suma_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                op_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic                overflow,
  output logic                zero
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;

  // Bit offset of the byte currently being processed.
  logic [IDXW+2:0] bit_base;
  logic [7:0]      add_a, add_b, add_s;
  logic            add_c;

  assign bit_base = {idx_q, 3'b000};
  assign add_a    = a_q[bit_base +: 8];
  assign add_b    = b_q[bit_base +: 8];

  Sumador_3 u_sumador (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_c)
  );

  // State, operand, carry and result registers; reset discards any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic: load on accept, one adder byte per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
          a_d     = op_a;
          b_d     = op_b ^ {W{op_sub}};
          carry_d = op_sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[bit_base +: 8] = add_s;
        carry_d              = add_c;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign carry_out = carry_q;
  // Signed overflow judged against the post-inversion B operand.
  assign overflow  = (a_q[W-1] == b_q[W-1]) && (res_q[W-1] != a_q[W-1]);
  assign zero      = ~|res_q;

endmodule
